// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial
// Purpose  : Bit-serial subtractor. Computes diff = a - b, LSB first, one bit
//            per clock. It uses a single full-subtractor cell and one borrow
//            flop. Operands are loaded in parallel and the result is returned
//            in parallel. A start/done/ack handshake holds each result until
//            the consumer takes it.
// Ports    : clk    - clock; all state updates on the rising edge
//            rst    - asynchronous, active-high reset
//            start  - request, sampled only in IDLE
//            a, b   - minuend / subtrahend, captured when start is accepted
//            ack    - result consumed, sampled only in DONE
//            busy   - state != IDLE
//            done   - state == DONE
//            diff   - (a - b) mod 2^WIDTH
//            borrow - unsigned borrow-out (a < b)
//            ovf    - two's-complement overflow of a - b
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_SUB  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_bw;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_ovf;

    logic w_accept;
    logic w_shift;
    logic w_last;
    logic w_d;
    logic w_bw_next;

    assign w_accept  = (r_state == c_S_IDLE) && start;
    assign w_shift   = (r_state == c_S_SUB);
    assign w_last    = (r_cnt == c_LAST);

    // One-bit full subtractor on the current LSBs and the running borrow
    assign w_d       = r_a[0] ^ r_b[0] ^ r_bw;
    assign w_bw_next = (~r_a[0] & r_b[0]) | (~r_a[0] & r_bw) | (r_b[0] & r_bw);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In DONE, start is ignored even alongside ack.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (start)  w_state_next = c_S_SUB;
            c_S_SUB:  if (w_last) w_state_next = c_S_DONE;
            c_S_DONE: if (ack)    w_state_next = c_S_IDLE;
            default:              w_state_next = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_shift) begin
            // Result bits enter at the MSB. After WIDTH shifts, bit 0 holds
            // the first (LSB) result bit.
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_bw   <= w_bw_next;
            r_cnt  <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_borrow <= w_bw_next;
                // Overflow when the operand signs differ and the result sign
                // differs from the minuend sign
                r_ovf    <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
            end
        end
    end

    assign busy   = (r_state != c_S_IDLE);
    assign done   = (r_state == c_S_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_serial
// Purpose  : Directed self-checking bench for sub_serial (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_serial;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ack    (ack),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and start; return just after the accepting edge
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_done", done, 1'b0);
    endtask

    // From just after the accepting edge, wait for the WIDTH SUB edges
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] ed,
                               input logic eb, input logic eo);
        repeat (WIDTH - 1) tick();
        check({tag, "_done_early"}, done, 1'b0);
        check({tag, "_busy_sub"},   busy, 1'b1);
        tick();
        check({tag, "_done"},   done,   1'b1);
        check({tag, "_busy"},   busy,   1'b1);
        check({tag, "_diff"},   diff,   ed);
        check({tag, "_borrow"}, borrow, eb);
        check({tag, "_ovf"},    ovf,    eo);
    endtask

    task automatic ack_op();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_busy", busy, 1'b0);
        check("ack_done", done, 1'b0);
    endtask

    logic [WIDTH-1:0] bb_a [3];
    logic [WIDTH-1:0] bb_b [3];
    logic [WIDTH-1:0] bb_d [3];
    logic             bb_bw[3];
    logic             bb_ov[3];

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) tick();
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_diff",   diff,   8'h00);
        check("rst_borrow", borrow, 1'b0);
        check("rst_ovf",    ovf,    1'b0);
        rst = 1'b0;
        tick();

        // 5 - 3, result held while ack is low
        start_op(8'h05, 8'h03);
        wait_result("op05_03", 8'h02, 1'b0, 1'b0);
        repeat (3) tick();
        check("hold_done", done, 1'b1);
        check("hold_diff", diff, 8'h02);
        ack_op();
        check("idle_diff_kept", diff, 8'h02);

        start_op(8'h03, 8'h05);
        wait_result("op03_05", 8'hFE, 1'b1, 1'b0);
        ack_op();
        start_op(8'h00, 8'h00);
        wait_result("op00_00", 8'h00, 1'b0, 1'b0);
        ack_op();
        start_op(8'h80, 8'h01);
        wait_result("op80_01", 8'h7F, 1'b0, 1'b1);
        ack_op();
        start_op(8'h7F, 8'hFF);
        wait_result("op7F_FF", 8'h80, 1'b1, 1'b1);
        ack_op();

        // Operands changed mid-operation must not affect the result
        start_op(8'h5A, 8'h21);
        repeat (3) tick();
        a = 8'hFF;
        b = 8'hFF;
        repeat (WIDTH - 4) tick();
        check("cap_done_early", done, 1'b0);
        tick();
        check("cap_diff",   diff,   8'h39);
        check("cap_borrow", borrow, 1'b0);
        check("cap_ovf",    ovf,    1'b0);

        // start together with ack in DONE: only return to IDLE
        a     = 8'h20;
        b     = 8'h30;
        start = 1'b1;
        ack   = 1'b1;
        tick();
        ack = 1'b0;
        check("sa_busy", busy, 1'b0);
        check("sa_done", done, 1'b0);
        // start still high: accepted on this next edge
        tick();
        start = 1'b0;
        check("sa_next_busy", busy, 1'b1);
        wait_result("op20_30", 8'hF0, 1'b1, 1'b0);
        ack_op();

        // Back-to-back with ack and start held high: period WIDTH+2
        bb_a[0] = 8'h10; bb_b[0] = 8'h20; bb_d[0] = 8'hF0; bb_bw[0] = 1'b1; bb_ov[0] = 1'b0;
        bb_a[1] = 8'hC8; bb_b[1] = 8'h37; bb_d[1] = 8'h91; bb_bw[1] = 1'b0; bb_ov[1] = 1'b0;
        bb_a[2] = 8'h00; bb_b[2] = 8'h80; bb_d[2] = 8'h80; bb_bw[2] = 1'b1; bb_ov[2] = 1'b1;
        ack   = 1'b1;
        a     = bb_a[0];
        b     = bb_b[0];
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();                                    // accepting edge
            check("bb_accept_busy", busy, 1'b1);
            if (i < 2) begin
                a = bb_a[i+1];
                b = bb_b[i+1];
            end
            repeat (WIDTH - 1) tick();
            check("bb_done_early", done, 1'b0);
            tick();
            check("bb_done",   done,   1'b1);
            check("bb_diff",   diff,   bb_d[i]);
            check("bb_borrow", borrow, bb_bw[i]);
            check("bb_ovf",    ovf,    bb_ov[i]);
            tick();                                    // ack edge
            check("bb_idle", busy, 1'b0);
            if (i == 2) begin
                start = 1'b0;
                ack   = 1'b0;
            end
        end
        tick();
        check("bb_stay_idle", busy, 1'b0);

        // Asynchronous reset on the 4th SUB cycle
        start_op(8'hAA, 8'h11);
        repeat (3) tick();
        check("pre_rst_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",   busy,   1'b0);
        check("arst_done",   done,   1'b0);
        check("arst_diff",   diff,   8'h00);
        check("arst_borrow", borrow, 1'b0);
        check("arst_ovf",    ovf,    1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 1'b0);
        start_op(8'h10, 8'h01);
        wait_result("op10_01", 8'h0F, 1'b0, 1'b0);
        ack_op();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
